// File: rtl/frame_burst_arbiter_pkg.sv
// frame_arb_pkg: shared state encodings and channel indices for the frame burst arbiter.
package frame_arb_pkg;
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;
    typedef logic [1:0] ch_t;
    localparam ch_t CH_RD0 = 2'd0;
    localparam ch_t CH_RD1 = 2'd1;
    localparam ch_t CH_WR0 = 2'd2;
    localparam ch_t CH_WR1 = 2'd3;
endpackage

// File: rtl/frame_burst_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker starting after the last grant.
module rr_pick4
    import frame_arb_pkg::*;
(
    input  logic [3:0] req,
    input  ch_t        last,
    output logic       found,
    output ch_t        idx
);
    // Scan farthest-first so the nearest requester after last wins.
    always_comb begin
        found = 1'b0;
        idx   = last;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                found = 1'b1;
                idx   = last + 2'(i);
            end
        end
    end
endmodule

// File: rtl/frame_burst_arbiter.sv
// frame_burst_arbiter: round-robin arbitration of two read and two write frame
// channels onto the single read/write ports of the DDR3 controller user interface.
module frame_burst_arbiter
    import frame_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10
) (
    input  logic                     rst,
    input  logic                     mem_clk,
    input  logic                     rd0_burst_req,
    input  logic [BURST_BITS-1:0]    rd0_burst_len,
    input  logic [ADDR_BITS-1:0]     rd0_burst_addr,
    output logic                     rd0_burst_data_valid,
    output logic                     rd0_burst_finish,
    input  logic                     rd1_burst_req,
    input  logic [BURST_BITS-1:0]    rd1_burst_len,
    input  logic [ADDR_BITS-1:0]     rd1_burst_addr,
    output logic                     rd1_burst_data_valid,
    output logic                     rd1_burst_finish,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data_out,
    input  logic                     wr0_burst_req,
    input  logic [BURST_BITS-1:0]    wr0_burst_len,
    input  logic [ADDR_BITS-1:0]     wr0_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] wr0_burst_data,
    output logic                     wr0_burst_data_req,
    output logic                     wr0_burst_finish,
    input  logic                     wr1_burst_req,
    input  logic [BURST_BITS-1:0]    wr1_burst_len,
    input  logic [ADDR_BITS-1:0]     wr1_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] wr1_burst_data,
    output logic                     wr1_burst_data_req,
    output logic                     wr1_burst_finish,
    output logic                     rd_burst_req,
    output logic [BURST_BITS-1:0]    rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic                     rd_burst_finish,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     wr_burst_req,
    output logic [BURST_BITS-1:0]    wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    input  logic                     wr_burst_finish,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data
);
    state_t                state, state_nx;
    ch_t                   grant, grant_nx, last_grant, last_nx, pick;
    logic                  found, is_wr, strobe, fin;
    logic [3:0]            gsel;
    logic [BURST_BITS-1:0] len_q, len_nx;
    logic [ADDR_BITS-1:0]  addr_q, addr_nx;
    logic [BURST_BITS-1:0] len_in [4];
    logic [ADDR_BITS-1:0]  addr_in [4];

    assign len_in  = '{rd0_burst_len, rd1_burst_len, wr0_burst_len, wr1_burst_len};
    assign addr_in = '{rd0_burst_addr, rd1_burst_addr, wr0_burst_addr, wr1_burst_addr};

    rr_pick4 u_pick (
        .req   ({wr1_burst_req, wr0_burst_req, rd1_burst_req, rd0_burst_req}),
        .last  (last_grant),
        .found (found),
        .idx   (pick)
    );

    assign is_wr  = grant[1];
    assign strobe = is_wr ? wr_burst_data_req : rd_burst_data_valid;
    assign fin    = is_wr ? wr_burst_finish : rd_burst_finish;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= CH_RD0;
            last_grant <= CH_WR1;
            len_q      <= '0;
            addr_q     <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_nx;
            len_q      <= len_nx;
            addr_q     <= addr_nx;
        end
    end

    // A burst aborted by an early finish does not advance the fairness pointer.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last_grant;
        len_nx   = len_q;
        addr_nx  = addr_q;
        case (state)
            S_IDLE: if (found) begin
                state_nx = S_GRANT;
                grant_nx = pick;
                len_nx   = len_in[pick];
                addr_nx  = addr_in[pick];
            end
            S_GRANT: state_nx = fin ? S_IDLE : strobe ? S_BUSY : S_GRANT;
            S_BUSY: if (fin) begin
                state_nx = S_IDLE;
                last_nx  = grant;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign gsel = (state != S_IDLE) ? (4'b0001 << grant) : 4'b0000;

    assign rd_burst_req  = (state == S_GRANT) && !is_wr;
    assign wr_burst_req  = (state == S_GRANT) && is_wr;
    assign rd_burst_len  = len_q;
    assign wr_burst_len  = len_q;
    assign rd_burst_addr = addr_q;
    assign wr_burst_addr = addr_q;

    assign rd0_burst_data_valid = gsel[CH_RD0] & rd_burst_data_valid;
    assign rd1_burst_data_valid = gsel[CH_RD1] & rd_burst_data_valid;
    assign rd0_burst_finish     = gsel[CH_RD0] & rd_burst_finish;
    assign rd1_burst_finish     = gsel[CH_RD1] & rd_burst_finish;
    assign wr0_burst_data_req   = gsel[CH_WR0] & wr_burst_data_req;
    assign wr1_burst_data_req   = gsel[CH_WR1] & wr_burst_data_req;
    assign wr0_burst_finish     = gsel[CH_WR0] & wr_burst_finish;
    assign wr1_burst_finish     = gsel[CH_WR1] & wr_burst_finish;
    assign rd_burst_data_out    = rd_burst_data;
    assign wr_burst_data        = gsel[CH_WR0] ? wr0_burst_data :
                                  gsel[CH_WR1] ? wr1_burst_data : '0;
endmodule
